pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It combines the ID load-use stall, EX taken-branch redirect, multi-cycle mul/div occupancy and data-memory wait into per-stage register enables and bubble controls. A small FSM holds the pipeline across multi-cycle events. Sits beside the ID-stage hazard detection; drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.

Parameters:
MEM_TIMEOUT, 255, MEM_WAIT cycles after which mem_timeout is raised (1..255)
TO_W, 8, width of timeout counter; must satisfy MEM_TIMEOUT < 2^TO_W

Ports:
clk  input  1  pipeline clock
rst_n  input  1  reset; asynchronous and active-low
load_use_ID  input  1  load-use stall request from ID hazard detection
branch_taken_EX  input  1  EX-stage branch/jump resolved taken
md_start_EX  input  1  EX holds a mul/div instruction needing the multi-cycle unit
md_done  input  1  mul/div result valid this cycle (1-cycle pulse)
dmem_req_MEM  input  1  MEM-stage load/store access active
dmem_ready  input  1  data memory completes access this cycle
md_go  output  1  1-cycle start pulse to mul/div unit
pc_en, ifid_en, idex_en, exmem_en, memwb_en  output  1 each  register load enables
ifid_flush, idex_flush, exmem_flush, memwb_flush  output  1 each  load NOP into that register
mem_timeout  output  1  sticky error: MEM_WAIT exceeded MEM_TIMEOUT
state_o  output  2  current state, for debug

Behaviour:
- States: RUN=0, MD_WAIT=1, MEM_WAIT=2; 3 unused -> RUN next edge, outputs as RUN.
- Reset (async, rst_n=0): state=RUN, timeout counter=0, mem_timeout=0, md_go=0. Outputs are combinational from state/inputs; with all inputs 0 in RUN: all *_en=1, all *_flush=0.
- Default (no event): all enables 1, flushes 0.
- RUN priority, highest first, evaluated same cycle (0-cycle latency):
  1. dmem_req_MEM & !dmem_ready: all enables 0, memwb_flush=1; next=MEM_WAIT.
  2. md_start_EX: md_go=1; pc_en=ifid_en=idex_en=0, exmem_flush=1; next=MD_WAIT.
  3. branch_taken_EX: ifid_flush=1, idex_flush=1, enables 1.
  4. load_use_ID: pc_en=0, ifid_en=0, idex_flush=1.
- MD_WAIT: pc/ifid/idex enables 0, exmem_flush=1, md_go=0, until md_done. On md_done cycle: outputs evaluated as RUN with md_start_EX masked (rules 1,3,4 apply); next=RUN, or MEM_WAIT if rule 1 fires.
- MEM_WAIT: all enables 0, memwb_flush=1; counter increments, saturating at 2^TO_W-1. On dmem_ready: outputs as RUN with dmem_req_MEM masked; counter cleared; next state per rules 2-4 (MD_WAIT if md_start_EX, else RUN).
- mem_timeout set on the edge the counter reaches MEM_TIMEOUT while in MEM_WAIT; stays 1 until reset. FSM keeps waiting.
- Flush beats enable: a register with flush=1 loads NOP regardless of its enable.
- md_done outside MD_WAIT ignored. rst_n low mid-wait: immediate return to RUN, counter 0.

Optional Feature:
PIPE_STALL_CNT_EN: when defined, adds outputs stall_cycles[31:0] (cycles with pc_en=0) and flush_cycles[31:0] (cycles with ifid_flush=1), wrapping at 2^32, reset to 0. Undefined: ports and counters absent, behaviour otherwise identical.

Test Plan:
- Reset then idle inputs -> state_o=0, all enables 1, flushes 0, mem_timeout=0.
- load_use_ID=1 for 1 cycle -> pc_en=0, ifid_en=0, idex_flush=1 that cycle only; next cycle defaults.
- md_start_EX=1, md_done pulsed 5 cycles later -> md_go high 1 cycle, state_o=1 for 5 cycles, exmem_flush=1 throughout; RUN after md_done.
- dmem_req_MEM=1, dmem_ready=0 with branch_taken_EX=1 -> mem stall wins: all enables 0, ifid_flush=0; ready after 3 cycles -> branch flush applied on ready cycle.
- MEM_TIMEOUT=4, dmem_ready held 0 for 10 cycles -> mem_timeout rises after 4th wait cycle, stays 1 after ready and until rst_n low.
- rst_n asserted while state_o=1 -> state_o=0 asynchronously, outputs return to defaults.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: per-stage enables, bubble controls and multi-cycle hold FSM.
// Optional PIPE_STALL_CNT_EN adds stall_cycles/flush_cycles performance counters.
module pipeline_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned TO_W        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_use_ID,
    input  logic       branch_taken_EX,
    input  logic       md_start_EX,
    input  logic       md_done,
    input  logic       dmem_req_MEM,
    input  logic       dmem_ready,
    output logic       md_go,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       idex_en,
    output logic       exmem_en,
    output logic       memwb_en,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       exmem_flush,
    output logic       memwb_flush,
    output logic       mem_timeout,
    output logic [1:0] state_o
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_cycles
`endif
);

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MD_WAIT  = 2'd1;
    localparam logic [1:0] MEM_WAIT = 2'd2;

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

    logic [1:0]      state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_inc;
    logic            run_eval, mask_md, mask_mem, mem_stall, md_req;

    // Wait-state exit cycles reuse the RUN priority chain with the completing request masked.
    always_comb begin
        md_go       = 1'b0;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        state_d     = state_q;
        run_eval    = 1'b0;
        mask_md     = 1'b0;
        mask_mem    = 1'b0;

        case (state_q)
            MD_WAIT: begin
                if (md_done) begin
                    run_eval = 1'b1;
                    mask_md  = 1'b1;
                end else begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_en     = 1'b0;
                    exmem_flush = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    run_eval = 1'b1;
                    mask_mem = 1'b1;
                end else begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_en     = 1'b0;
                    exmem_en    = 1'b0;
                    memwb_en    = 1'b0;
                    memwb_flush = 1'b1;
                end
            end
            default: run_eval = 1'b1;
        endcase

        mem_stall = dmem_req_MEM & ~dmem_ready & ~mask_mem;
        md_req    = md_start_EX & ~mask_md;

        if (run_eval) begin
            state_d = RUN;
            if (mem_stall) begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_en     = 1'b0;
                exmem_en    = 1'b0;
                memwb_en    = 1'b0;
                memwb_flush = 1'b1;
                state_d     = MEM_WAIT;
            end else if (md_req) begin
                md_go       = 1'b1;
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_en     = 1'b0;
                exmem_flush = 1'b1;
                state_d     = MD_WAIT;
            end else if (branch_taken_EX) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use_ID) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
        end

        // Unused encoding behaves as RUN for one cycle, then recovers unconditionally.
        if (state_q == 2'd3) state_d = RUN;

        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + TO_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == MEM_WAIT && !dmem_ready) begin
                cnt_q <= cnt_inc;
                if (cnt_inc == TO_LIMIT) mem_timeout <= 1'b1;
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign state_o = state_q;

`ifdef PIPE_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            if (!pc_en)     stall_cycles <= stall_cycles + 32'd1;
            if (ifid_flush) flush_cycles <= flush_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with hand-computed expected output vectors.
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_use_ID, branch_taken_EX, md_start_EX, md_done, dmem_req_MEM, dmem_ready;
    logic       md_go, pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_flush, exmem_flush, memwb_flush, mem_timeout;
    logic [1:0] state_o;
`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_cycles, flush_cycles;
`endif

    int checks = 0;
    int fails  = 0;

    // Vector layout: {md_go, en[pc,ifid,idex,exmem,memwb], flush[ifid,idex,exmem,memwb], mem_timeout, state}
    logic [12:0] obs;
    assign obs = {md_go, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                  ifid_flush, idex_flush, exmem_flush, memwb_flush, mem_timeout, state_o};

    localparam logic [4:0] ALL  = 5'b11111;
    localparam logic [4:0] NONE = 5'b00000;
    localparam logic [4:0] MDS  = 5'b00011;
    localparam logic [4:0] LU   = 5'b00111;
    localparam logic [3:0] FL0  = 4'b0000;
    localparam logic [3:0] FLW  = 4'b0001;
    localparam logic [3:0] FLX  = 4'b0010;
    localparam logic [3:0] FLI  = 4'b0100;
    localparam logic [3:0] FLB  = 4'b1100;

    pipeline_ctrl #(.MEM_TIMEOUT(4), .TO_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_use_ID(load_use_ID), .branch_taken_EX(branch_taken_EX),
        .md_start_EX(md_start_EX), .md_done(md_done),
        .dmem_req_MEM(dmem_req_MEM), .dmem_ready(dmem_ready),
        .md_go(md_go), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .mem_timeout(mem_timeout), .state_o(state_o)
`ifdef PIPE_STALL_CNT_EN
        , .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] ex(logic g, logic [4:0] en, logic [3:0] fl, logic to, logic [1:0] st);
        return {g, en, fl, to, st};
    endfunction

    task automatic at(input string tag, input logic [12:0] e);
        #1;
        checks++;
        assert (obs === e) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, e);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        load_use_ID = 0; branch_taken_EX = 0; md_start_EX = 0;
        md_done = 0; dmem_req_MEM = 0; dmem_ready = 0;
    endtask

    initial begin
        idle_in();
        rst_n = 0;
        #2;
        at("reset", ex(0, ALL, FL0, 0, 2'd0));
        cyc(); cyc();
        rst_n = 1;
        cyc();
        at("idle", ex(0, ALL, FL0, 0, 2'd0));

        load_use_ID = 1;
        at("load_use", ex(0, LU, FLI, 0, 2'd0));
        cyc();
        load_use_ID = 0;
        at("load_use_after", ex(0, ALL, FL0, 0, 2'd0));

        branch_taken_EX = 1; load_use_ID = 1;
        at("branch_over_lu", ex(0, ALL, FLB, 0, 2'd0));
        cyc();
        idle_in();

        md_done = 1;
        at("md_done_in_run", ex(0, ALL, FL0, 0, 2'd0));
        cyc();
        md_done = 0;
        at("md_done_ignored", ex(0, ALL, FL0, 0, 2'd0));

        md_start_EX = 1;
        at("md_start", ex(1, MDS, FLX, 0, 2'd0));
        cyc();
        md_start_EX = 0;
        for (int i = 1; i <= 4; i++) begin
            at($sformatf("md_wait%0d", i), ex(0, MDS, FLX, 0, 2'd1));
            cyc();
        end
        md_done = 1;
        at("md_done", ex(0, ALL, FL0, 0, 2'd1));
        cyc();
        md_done = 0;
        at("md_back_run", ex(0, ALL, FL0, 0, 2'd0));

        dmem_req_MEM = 1; branch_taken_EX = 1;
        at("mem_over_branch", ex(0, NONE, FLW, 0, 2'd0));
        cyc();
        at("mem_wait1", ex(0, NONE, FLW, 0, 2'd2));
        cyc();
        at("mem_wait2", ex(0, NONE, FLW, 0, 2'd2));
        cyc();
        dmem_ready = 1;
        at("mem_ready_branch", ex(0, ALL, FLB, 0, 2'd2));
        cyc();
        idle_in();
        at("mem_back_run", ex(0, ALL, FL0, 0, 2'd0));

        dmem_req_MEM = 1; md_start_EX = 1;
        at("mem_over_md", ex(0, NONE, FLW, 0, 2'd0));
        cyc();
        dmem_ready = 1;
        at("mem_ready_md", ex(1, MDS, FLX, 0, 2'd2));
        cyc();
        md_start_EX = 0; dmem_ready = 0; md_done = 1;
        at("md_done_mem", ex(0, NONE, FLW, 0, 2'd1));
        cyc();
        md_done = 0; dmem_ready = 1;
        at("mem_ready_plain", ex(0, ALL, FL0, 0, 2'd2));
        cyc();
        idle_in();
        at("chain_back_run", ex(0, ALL, FL0, 0, 2'd0));

        dmem_req_MEM = 1;
        at("to_enter", ex(0, NONE, FLW, 0, 2'd0));
        cyc();
        for (int i = 1; i <= 10; i++) begin
            at($sformatf("to_wait%0d", i), ex(0, NONE, FLW, (i >= 5), 2'd2));
            cyc();
        end
        dmem_ready = 1;
        at("to_ready", ex(0, ALL, FL0, 1, 2'd2));
        cyc();
        idle_in();
        at("to_sticky", ex(0, ALL, FL0, 1, 2'd0));
        cyc();

        md_start_EX = 1;
        at("md_start2", ex(1, MDS, FLX, 1, 2'd0));
        cyc();
        md_start_EX = 0;
        at("md_wait_pre_rst", ex(0, MDS, FLX, 1, 2'd1));
        rst_n = 0;
        at("async_rst", ex(0, ALL, FL0, 0, 2'd0));
        cyc();
        rst_n = 1;
        cyc();
        at("post_rst_idle", ex(0, ALL, FL0, 0, 2'd0));

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
